// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG output path: writer FSM states and 8x8 block geometry.
package jpeg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } blk_state_t;

    localparam int WORDS_PER_LINE  = 2;
    localparam int LINES_PER_BLOCK = 8;
    localparam int BLOCK_BYTES_X   = 8;
    localparam int WORD_BYTES      = 4;

    // Byte distance between the tops of two vertically adjacent block rows.
    function automatic logic [31:0] row_stride(input logic [11:0] pitch);
        return 32'(pitch) << $clog2(LINES_PER_BLOCK);
    endfunction

endpackage

// File: rtl/wr_fifo.sv
// Small synchronous word FIFO with flush; pointers carry an extra wrap bit for full/empty.
module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/blk_writer.sv
// Block writer: drains 8x8 pixel blocks from an input word FIFO into memory as
// single Wishbone write cycles, walking the frame block by block in raster order.
module blk_writer
    import jpeg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] dst_addr_i,
    input  logic [11:0] pitch_i,
    input  logic [7:0]  endblock_x_i,
    input  logic [7:0]  endblock_y_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam logic       X_LAST = 1'(WORDS_PER_LINE - 1);
    localparam logic [2:0] Y_LAST = 3'(LINES_PER_BLOCK - 1);

    blk_state_t  r_state;
    logic [11:0] r_pitch;
    logic [7:0]  r_endx;
    logic [7:0]  r_endy;
    logic        r_x;
    logic [2:0]  r_y;
    logic [7:0]  r_bx;
    logic [7:0]  r_by;
    logic [31:0] r_addr;
    logic [31:0] r_line_base;
    logic [31:0] r_blk_base;
    logic [31:0] r_row_base;
    logic [31:0] r_wb_adr;
    logic [31:0] r_wb_dat;
    logic        r_err;

    logic        w_write;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_last;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [31:0] w_head;
    logic [31:0] w_next_line;
    logic [31:0] w_next_blk;
    logic [31:0] w_next_row;

    assign w_write  = (r_state == ST_WRITE);
    assign busy_o   = (r_state == ST_FETCH) || w_write;
    assign ready_o  = busy_o && !w_fifo_full;
    assign done_o   = (r_state == ST_DONE);
    assign err_o    = r_err;
    assign wb_cyc_o = w_write;
    assign wb_stb_o = w_write;
    assign wb_we_o  = w_write;
    assign wb_sel_o = w_write ? 4'hF : 4'h0;
    assign wb_adr_o = r_wb_adr;
    assign wb_dat_o = r_wb_dat;

    // A restart wins over a same-cycle ack: the word in flight is dropped with the flush.
    assign w_push  = valid_i && ready_o;
    assign w_pop   = w_write && wb_ack_i && !wb_err_i && !start_i;
    assign w_flush = start_i || (r_state == ST_DONE);
    assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST) &&
                     (r_bx == r_endx) && (r_by == r_endy);

    assign w_next_line = r_line_base + 32'(r_pitch);
    assign w_next_blk  = r_blk_base + 32'(BLOCK_BYTES_X);
    assign w_next_row  = r_row_base + row_stride(r_pitch);

    wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (data_i),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_pitch  <= '0;
            r_endx   <= '0;
            r_endy   <= '0;
            r_wb_adr <= '0;
            r_wb_dat <= '0;
            r_err    <= 1'b0;
        end else if (start_i) begin
            r_state <= ST_FETCH;
            r_pitch <= pitch_i;
            r_endx  <= endblock_x_i;
            r_endy  <= endblock_y_i;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (!w_fifo_empty) begin
                        r_wb_adr <= r_addr;
                        r_wb_dat <= w_head;
                        r_state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wb_err_i) begin
                        r_state <= ST_ERR;
                        r_err   <= 1'b1;
                    end else if (wb_ack_i) begin
                        r_state <= w_last ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= r_state;
            endcase
        end
    end

    // Address walk: word within line, line within block, block within row, block row.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_x         <= 1'b0;
            r_y         <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_addr      <= '0;
            r_line_base <= '0;
            r_blk_base  <= '0;
            r_row_base  <= '0;
        end else if (start_i) begin
            r_x         <= 1'b0;
            r_y         <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_addr      <= dst_addr_i;
            r_line_base <= dst_addr_i;
            r_blk_base  <= dst_addr_i;
            r_row_base  <= dst_addr_i;
        end else if (w_pop) begin
            if (r_x != X_LAST) begin
                r_x    <= r_x + 1'b1;
                r_addr <= r_addr + 32'(WORD_BYTES);
            end else begin
                r_x <= 1'b0;
                if (r_y != Y_LAST) begin
                    r_y         <= r_y + 3'd1;
                    r_line_base <= w_next_line;
                    r_addr      <= w_next_line;
                end else begin
                    r_y <= '0;
                    if (r_bx != r_endx) begin
                        r_bx        <= r_bx + 8'd1;
                        r_blk_base  <= w_next_blk;
                        r_line_base <= w_next_blk;
                        r_addr      <= w_next_blk;
                    end else begin
                        r_bx        <= '0;
                        r_by        <= r_by + 8'd1;
                        r_row_base  <= w_next_row;
                        r_blk_base  <= w_next_row;
                        r_line_base <= w_next_row;
                        r_addr      <= w_next_row;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_blk_writer.sv
// Randomized self-checking bench for blk_writer against a transaction-level frame model.
module tb_blk_writer;

    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] dst_addr_i;
    logic [11:0] pitch_i;
    logic [7:0]  endblock_x_i;
    logic [7:0]  endblock_y_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    blk_writer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dst_addr_i(dst_addr_i),
        .pitch_i(pitch_i), .endblock_x_i(endblock_x_i), .endblock_y_i(endblock_y_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // stimulus control, written by the main sequence only
    int frame_gen = 0;
    int prod_total = 0;
    int prod_rate = 100;
    logic prod_en = 1'b0;
    int ack_delay = 0;
    int err_at = 0;

    // model state, written by the monitor only
    logic [31:0] m_dst = '0;
    logic [11:0] m_pitch = '0;
    logic [7:0]  m_ex = '0;
    logic [7:0]  m_ey = '0;
    int          m_idx = 0;
    int          m_total = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] adr_log[$];
    logic        prev_drop = 1'b0;
    logic        prev_pending = 1'b0;
    logic        prev_cyc = 1'b0;
    logic [31:0] prev_adr = '0;
    logic [31:0] prev_dat = '0;
    logic        acc_last = 1'b0;
    int          bp_seen = 0;
    int          wr_starts = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Address of write number idx, straight from the frame geometry.
    function automatic logic [31:0] exp_addr(input int idx);
        int x, y, blk, bx, by;
        x   = idx % 2;
        y   = (idx / 2) % 8;
        blk = idx / 16;
        bx  = blk % (int'(m_ex) + 1);
        by  = blk / (int'(m_ex) + 1);
        return m_dst + 32'(by) * 32'(m_pitch) * 32'd8 + 32'(bx) * 32'd8
                     + 32'(y) * 32'(m_pitch) + 32'(x) * 32'd4;
    endfunction

    // Monitor: compare outputs to the model, then advance the model by what the next edge will see.
    always @(negedge clk_i) begin
        if (rst_i) begin
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            exp_q.delete();
            prev_drop = 1'b0; prev_pending = 1'b0; prev_cyc = 1'b0; acc_last = 1'b0;
        end else begin
            chk1("busy_o", busy_o, m_busy);
            chk1("ready_o", ready_o, m_busy && (exp_q.size() < DEPTH));
            chk1("done_o", done_o, m_done);
            chk1("err_o", err_o, m_err);
            if (prev_drop) chk1("cyc_drop", wb_cyc_o, 1'b0);
            if (wb_cyc_o) begin
                chk1("stb_o", wb_stb_o, 1'b1);
                chk1("we_o", wb_we_o, 1'b1);
                chk("sel_o", {28'd0, wb_sel_o}, 32'hF);
                chk1("cyc_only_when_busy", busy_o, 1'b1);
                if (prev_pending) begin
                    chk("adr_stable", wb_adr_o, prev_adr);
                    chk("dat_stable", wb_dat_o, prev_dat);
                end
            end else begin
                chk1("stb_without_cyc", wb_stb_o, 1'b0);
            end
            if (busy_o && !ready_o) bp_seen++;
            if (wb_cyc_o && !prev_cyc) wr_starts++;
            if (done_o) done_cnt++;

            m_done = 1'b0;
            prev_drop = 1'b0;
            if (start_i) begin
                m_dst = dst_addr_i; m_pitch = pitch_i; m_ex = endblock_x_i; m_ey = endblock_y_i;
                m_idx = 0;
                m_total = (int'(endblock_x_i) + 1) * (int'(endblock_y_i) + 1) * 16;
                m_busy = 1'b1; m_err = 1'b0;
                exp_q.delete(); adr_log.delete();
                bp_seen = 0; wr_starts = 0;
                prev_drop = 1'b1;
            end else begin
                if (valid_i && ready_o) exp_q.push_back(data_i);
                if (wb_cyc_o && wb_err_i) begin
                    m_err = 1'b1; m_busy = 1'b0; prev_drop = 1'b1; err_cnt++;
                end else if (wb_cyc_o && wb_ack_i) begin
                    chk("wb_adr_o", wb_adr_o, exp_addr(m_idx));
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL wb_dat_o: write 0x%08h with no accepted word pending", wb_dat_o);
                    end else begin
                        chk("wb_dat_o", wb_dat_o, exp_q.pop_front());
                    end
                    adr_log.push_back(wb_adr_o);
                    m_idx++;
                    prev_drop = 1'b1;
                    if (m_idx == m_total) begin
                        m_busy = 1'b0; m_done = 1'b1; exp_q.delete();
                    end
                end
            end
            acc_last = valid_i && ready_o && !start_i;
            prev_cyc = wb_cyc_o;
            prev_pending = wb_cyc_o && !wb_ack_i && !wb_err_i && !start_i;
            prev_adr = wb_adr_o;
            prev_dat = wb_dat_o;
        end
    end

    // Word producer: offers random words, holding each until accepted.
    initial begin
        int my_gen;
        int sent;
        my_gen = 0; sent = 0;
        valid_i = 1'b0; data_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (my_gen != frame_gen) begin
                my_gen = frame_gen; sent = 0; valid_i = 1'b0;
            end else if (acc_last) begin
                sent++; valid_i = 1'b0;
            end
            if (!prod_en || sent >= prod_total) valid_i = 1'b0;
            else if (!valid_i && $urandom_range(0, 99) < prod_rate) begin
                valid_i = 1'b1; data_i = $urandom();
            end
        end
    end

    // Wishbone slave: acks after a programmable or random wait, optionally errors one write.
    initial begin
        int my_gen, cnt, n, dly;
        my_gen = 0; cnt = 0; n = 0; dly = 0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            wb_ack_i = 1'b0; wb_err_i = 1'b0;
            if (my_gen != frame_gen) begin
                my_gen = frame_gen; n = 0; cnt = 0;
                dly = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            end
            if (rst_i || !wb_cyc_o) cnt = 0;
            else if (cnt >= dly) begin
                if (n + 1 == err_at) wb_err_i = 1'b1;
                else wb_ack_i = 1'b1;
                n++; cnt = 0;
                dly = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
            end else cnt++;
        end
    end

    task automatic start_frame(input logic [31:0] dst, input logic [11:0] pitch,
                               input logic [7:0] ex, input logic [7:0] ey,
                               input int rate, input int delay, input int errat);
        prod_en = 1'b0;
        @(posedge clk_i); #2;
        start_i = 1'b1;
        dst_addr_i = dst; pitch_i = pitch; endblock_x_i = ex; endblock_y_i = ey;
        ack_delay = delay; err_at = errat; prod_rate = rate;
        prod_total = (int'(ex) + 1) * (int'(ey) + 1) * 16;
        frame_gen++;
        @(posedge clk_i); #2;
        start_i = 1'b0;
        dst_addr_i = $urandom(); pitch_i = 12'($urandom()); endblock_x_i = 8'($urandom());
        endblock_y_i = 8'($urandom());
        prod_en = 1'b1;
    endtask

    // mode 0: done pulses, 1: error responses, 2: write cycles started, 3: cyc high
    function automatic bit reached(input int mode, input int target);
        case (mode)
            0: return done_cnt >= target;
            1: return err_cnt >= target;
            2: return wr_starts >= target;
            default: return wb_cyc_o === 1'b1;
        endcase
    endfunction

    task automatic wait_for(input int mode, input int target, input int limit, input string name);
        int n;
        n = 0;
        while (!reached(mode, target) && n < limit) begin
            @(negedge clk_i); n++;
        end
        checks++;
        if (!reached(mode, target)) begin
            failures++;
            $display("FAIL %s: timeout after %0d cycles waiting for target %0d", name, limit, target);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
        chk({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
        chk({tag, "_we"}, {31'd0, wb_we_o}, 32'd0);
        chk({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
        chk({tag, "_adr"}, wb_adr_o, 32'd0);
        chk({tag, "_dat"}, wb_dat_o, 32'd0);
        chk({tag, "_ready"}, {31'd0, ready_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_done"}, {31'd0, done_o}, 32'd0);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        int exp_done;
        exp_done = 0;
        rst_i = 1'b1; start_i = 1'b0;
        dst_addr_i = '0; pitch_i = '0; endblock_x_i = '0; endblock_y_i = '0;
        #3;
        chk_all_zero("reset");
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;

        // single block, ack every cycle
        start_frame(32'h1000, 12'd64, 8'd0, 8'd0, 100, 0, 0);
        exp_done++;
        wait_for(0, exp_done, 400, "single_done");
        repeat (3) @(negedge clk_i);
        chk("single_done_count", 32'(done_cnt), 32'(exp_done));
        chk("single_writes", 32'(adr_log.size()), 32'd16);
        chk("single_adr0", adr_log[0], 32'h1000);
        chk("single_adr1", adr_log[1], 32'h1004);
        chk("single_adr2", adr_log[2], 32'h1040);
        chk("single_adr3", adr_log[3], 32'h1044);
        chk("single_adr15", adr_log[15], 32'h11C4);

        // 2x2 blocks
        start_frame(32'h2000, 12'd16, 8'd1, 8'd1, 100, 0, 0);
        exp_done++;
        wait_for(0, exp_done, 1500, "quad_done");
        repeat (3) @(negedge clk_i);
        chk("quad_done_count", 32'(done_cnt), 32'(exp_done));
        chk("quad_writes", 32'(adr_log.size()), 32'd64);
        chk("quad_adr16", adr_log[16], 32'h2008);
        chk("quad_adr32", adr_log[32], 32'h2080);
        chk("quad_adr48", adr_log[48], 32'h2088);
        chk("quad_adr63", adr_log[63], 32'h20FC);

        // backpressure: slow slave, continuous producer
        start_frame(32'h4000, 12'd32, 8'd0, 8'd1, 100, 3, 0);
        exp_done++;
        wait_for(0, exp_done, 1500, "bp_done");
        repeat (2) @(negedge clk_i);
        chk1("bp_ready_low_seen", bp_seen > 0, 1'b1);
        chk("bp_writes", 32'(adr_log.size()), 32'd32);

        // bus error on the 5th write
        start_frame(32'h5000, 12'd64, 8'd0, 8'd0, 100, 0, 5);
        wait_for(1, 1, 400, "err_seen");
        repeat (4) @(negedge clk_i);
        chk1("err_sticky", err_o, 1'b1);
        chk1("err_cyc_low", wb_cyc_o, 1'b0);
        chk("err_writes_acked", 32'(adr_log.size()), 32'd4);
        chk("err_no_done", 32'(done_cnt), 32'(exp_done));
        start_frame(32'h6000, 12'd128, 8'd0, 8'd0, 100, 1, 0);
        chk1("err_cleared_by_start", err_o, 1'b0);
        exp_done++;
        wait_for(0, exp_done, 600, "after_err_done");

        // abort during the 3rd write
        start_frame(32'h7000, 12'd64, 8'd1, 8'd0, 100, 4, 0);
        wait_for(2, 3, 400, "abort_third_write");
        start_frame(32'h3000, 12'd64, 8'd0, 8'd0, 100, 0, 0);
        exp_done++;
        wait_for(0, exp_done, 600, "abort_new_done");
        repeat (3) @(negedge clk_i);
        chk("abort_done_count", 32'(done_cnt), 32'(exp_done));
        chk("abort_first_adr", adr_log[0], 32'h3000);
        chk("abort_writes", 32'(adr_log.size()), 32'd16);

        // random frames, random valid gaps and ack latency
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            d = (i == 0) ? 32'hFFFF_FF00 : $urandom();
            start_frame(d, 12'($urandom()), 8'($urandom_range(0, 2)), 8'($urandom_range(0, 1)),
                        int'($urandom_range(30, 100)), -1, 0);
            exp_done++;
            wait_for(0, exp_done, 4000, "rand_done");
        end
        repeat (3) @(negedge clk_i);
        chk("rand_done_count", 32'(done_cnt), 32'(exp_done));

        // asynchronous reset in the middle of a write
        start_frame(32'h8000, 12'd64, 8'd0, 8'd0, 100, 3, 0);
        wait_for(3, 0, 200, "reset_wait_cyc");
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk1("post_reset_busy", busy_o, 1'b0);
        start_frame(32'h9000, 12'd64, 8'd0, 8'd0, 100, 0, 0);
        exp_done++;
        wait_for(0, exp_done, 400, "post_reset_done");
        repeat (3) @(negedge clk_i);
        chk("post_reset_adr0", adr_log[0], 32'h9000);
        chk("final_done_count", 32'(done_cnt), 32'(exp_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blk_writer.md
BLK_WRITER -- requirements
Module: blk_writer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input word buffer depth (power of two, >=2).
REQ-002 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  one-cycle pulse; latches frame parameters and starts a frame.
REQ-005 SHALL have port dst_addr_i  input  32  byte address of frame top-left pixel.
REQ-006 SHALL have port pitch_i  input  12  frame line width in bytes.
REQ-007 SHALL have port endblock_x_i / endblock_y_i  input  8 each  blocks per row / column minus 1.
REQ-008 SHALL have ports data_i  input  32, valid_i  input  1, ready_o  output  1  pixel word stream, 4 pixels per word, 16 words per 8x8 block, raster order within block.
REQ-009 SHALL have Wishbone master ports wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1 (outputs), wb_ack_i 1, wb_err_i 1 (inputs).
REQ-010 SHALL have ports busy_o  output  1, done_o  output  1 (one-cycle pulse), err_o  output  1 (sticky).

Function
REQ-011 SHALL accept a word when valid_i && ready_o on a rising edge; ready_o = state in {FETCH, WRITE} && FIFO not full.
REQ-012 SHALL use states IDLE, FETCH, WRITE, DONE, ERR.
REQ-013 IDLE/DONE/ERR + start_i -> FETCH; latch parameters, clear counters, flush FIFO, clear err_o.
REQ-014 FETCH + FIFO non-empty -> WRITE next cycle with wb_adr_o = current address, wb_dat_o = FIFO head.
REQ-015 WRITE: wb_cyc_o=wb_stb_o=wb_we_o=1, wb_sel_o=4'hF, held stable until wb_ack_i or wb_err_i.
REQ-016 WRITE + wb_ack_i: pop FIFO, advance address; if last word of frame -> DONE, else -> FETCH (min 2 cycles/word).
REQ-017 WRITE + wb_err_i (priority over ack if both high) -> ERR; cyc/stb drop next cycle; err_o=1.
REQ-018 DONE: done_o=1 for exactly one cycle, then IDLE; residual FIFO words flushed.
REQ-019 Address walk: word x 0..1 (+4 bytes), line y 0..7 (line base + pitch), block bx 0..endblock_x (block base + 8), block row by 0..endblock_y (row base + pitch*8); 32-bit unsigned, wrap modulo 2^32.
REQ-020 Last word = x==1, y==7, bx==endblock_x, by==endblock_y; frame = (endblock_x+1)*(endblock_y+1)*16 writes.
REQ-021 start_i while in FETCH or WRITE SHALL abort: cyc/stb low next cycle, FIFO flushed, restart in FETCH with new parameters; no done_o.
REQ-022 busy_o = state in {FETCH, WRITE}.
REQ-023 Parameter inputs SHALL be sampled only on start_i; later changes have no effect on the current frame.

Reset
REQ-024 rst_i SHALL force immediately: state IDLE, FIFO empty, all counters/addresses 0, wb_cyc_o/wb_stb_o/wb_we_o 0, wb_sel_o 0, wb_adr_o/wb_dat_o 0, ready_o/busy_o/done_o/err_o 0.
REQ-025 Reset mid-transfer SHALL drop cyc/stb asynchronously; the word in flight is lost.

Structure
REQ-026 State enum and constants WORDS_PER_LINE=2, LINES_PER_BLOCK=8, BLOCK_BYTES_X=8 SHALL live in shared package jpeg_pkg.
REQ-027 Input buffer SHALL be sub-module wr_fifo (FIFO_DEPTH x 32, push/pop/full/empty/flush, async reset).

Verification
REQ-028 Single block: dst=0x1000, pitch=64, endblock 0/0, 16 words, ack each cycle -> addresses 0x1000,0x1004,0x1040,0x1044,...,0x11C4; done_o once after 16th ack.
REQ-029 2x2 blocks: dst=0x2000, pitch=16, endblock 1/1 -> block starts 0x2000,0x2008,0x2080,0x2088; 64 writes; done_o after 64th.
REQ-030 Backpressure: ack delayed 3 cycles, valid_i continuous -> ready_o low when 4 words buffered; no word lost or duplicated; data order preserved.
REQ-031 Error: wb_err_i on 5th write -> ERR, err_o=1, cyc low next cycle, no done_o; next start_i clears err_o.
REQ-032 Abort: start_i during 3rd write with dst=0x3000 -> cyc drops, first write of new frame at 0x3000 with first new word.
REQ-033 Reset: rst_i asserted mid-WRITE -> all outputs 0 in same cycle, state IDLE.
